ex_muldiv: RTL and testbench
============================

// Module: ex_muldiv
// PURPOSE
//  Iterative multiply/divide unit for the EX stage. It produces 2*DATA_WIDTH HI/LO results for
//  MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU. It sits beside the EX-stage ALU and drives the
//  HI/LO write path. It raises a stall request while an operation is in flight.
// PARAMETERS
//  DATA_WIDTH  32  operand width; HI and LO are each DATA_WIDTH bits
//  CNT_WIDTH   $clog2(DATA_WIDTH)+1  iteration counter width (derived, not overridden)
// PORTS
//  clock         in   1           rising-edge clock; the only clock
//  reset         in   1           asynchronous, active-low reset
//  start         in   1           one-cycle request pulse; at most one pulse per operation
//  op            in   3           `MD_OP_* encoding
//  operand1      in   DATA_WIDTH  multiplicand / dividend
//  operand2      in   DATA_WIDTH  multiplier / divisor
//  hi_in, lo_in  in   DATA_WIDTH  forwarded HI/LO accumulator; sampled at accept
//  annul         in   1           synchronous flush of the current operation
//  stall_request out  1           hold the pipeline
//  done          out  1           one-cycle pulse: result_hi/result_lo are valid
//  result_hi     out  DATA_WIDTH  HI result (remainder for divide)
//  result_lo     out  DATA_WIDTH  LO result (quotient for divide)
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE; done=0; result_hi=0; result_lo=0; counter and working regs=0.
//    This holds mid-operation; no done is produced afterwards.
//  - States: IDLE -> RUN -> FIX -> DONE -> IDLE.
//    An accept in DONE goes directly to RUN (back-to-back issue).
//  - Accept: start & ~annul while in IDLE or DONE. Start in RUN/FIX is ignored.
//    At accept, operands are latched as magnitudes (signed ops) with their sign flags, and hi_in/lo_in are latched.
//  - RUN: DATA_WIDTH cycles of radix-2 work.
//    Multiply: shift-add. Divide: restoring shift-subtract.
//  - FIX (1 cycle): apply sign correction, then:
//    MADD*: {hi,lo} = acc + product mod 2^(2W).
//    MSUB*: {hi,lo} = acc - product mod 2^(2W).
//  - DONE (1 cycle): done=1; result regs are written on entry to DONE.
//  - Latency: done is high in the cycle DATA_WIDTH+2 edges after the accepting edge.
//  - Holding: result_hi/result_lo hold their values until the next DONE entry or reset.
//  - stall_request = (accept this cycle) | (state==RUN) | (state==FIX); it is low in DONE.
//  - Signed divide: quotient sign = sign1^sign2; remainder sign = dividend sign.
//    MIN / -1 -> quotient=MIN, remainder=0 (wraps naturally).
//  - Divide by zero, either signedness: skip RUN and go IDLE->FIX->DONE.
//    result_lo = all ones; result_hi = operand1 as given.
//    done fires 2 edges after the accepting edge.
//  - annul: in any non-IDLE state, next edge -> IDLE. done stays 0; result regs are unchanged.
//    annul & start in the same cycle: annul wins and there is no accept.
//  - Unknown op at accept: treated as MULTU with no HI/LO write. done still pulses with the old results.
// STRUCTURE
//  - Add the `MD_OP_*` encodings (MULT=0, MULTU=1, DIV=2, DIVU=3, MADD=4, MADDU=5, MSUB=6, MSUBU=7)
//    and the `MD_STATE_*` encodings to macro.v.
//  - One sub-module, muldiv_step: combinational single radix-2 iteration.
//    Inputs: mode, partial {hi,lo}, operand. Output: next partial.
//  - This module holds the FSM, counter, sign fix and accumulate.
// TESTING (DATA_WIDTH=32)
//  1. MULT -3 x 5 -> {hi,lo}=FFFFFFFF_FFFFFFF1. done exactly 34 edges after accept;
//     stall_request high from the accept cycle through FIX.
//  2. DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//     DIV 0x80000000/-1 -> lo=80000000, hi=0.
//  3. DIV 5/0 -> lo=FFFFFFFF, hi=5; done 2 edges after accept.
//  4. MADDU with acc=00000000_FFFFFFFF, operands 2x1 -> hi=1, lo=1.
//     MSUBU with acc=0, operands 1x1 -> hi=lo=FFFFFFFF.
//  5. Back-to-back: second start in the DONE cycle is accepted; its done arrives 34 edges later.
//     A start pulse during RUN is ignored, so there is no extra done.
//  6. annul at RUN cycle 10 -> IDLE next edge, no done, results unchanged.
//     reset low mid-RUN -> all outputs 0 immediately, no done.

Source files
------------

// File: rtl/ex_muldiv_pkg.sv
// Shared encodings and decode helpers for the EX-stage iterative multiply/divide unit.
package ex_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_OP_MULT  = 3'd0,
    MD_OP_MULTU = 3'd1,
    MD_OP_DIV   = 3'd2,
    MD_OP_DIVU  = 3'd3,
    MD_OP_MADD  = 3'd4,
    MD_OP_MADDU = 3'd5,
    MD_OP_MSUB  = 3'd6,
    MD_OP_MSUBU = 3'd7
  } md_op_e;

  typedef enum logic [1:0] {
    MD_STATE_IDLE = 2'd0,
    MD_STATE_RUN  = 2'd1,
    MD_STATE_FIX  = 2'd2,
    MD_STATE_DONE = 2'd3
  } md_state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } md_step_e;

  function automatic logic is_signed_op(input md_op_e o);
    return o inside {MD_OP_MULT, MD_OP_DIV, MD_OP_MADD, MD_OP_MSUB};
  endfunction

  function automatic logic is_div_op(input md_op_e o);
    return o inside {MD_OP_DIV, MD_OP_DIVU};
  endfunction

  // Encodings outside the table would run as MULTU without writing HI/LO.
  function automatic logic is_known_op(input md_op_e o);
    return o inside {MD_OP_MULT, MD_OP_MULTU, MD_OP_DIV, MD_OP_DIVU,
                     MD_OP_MADD, MD_OP_MADDU, MD_OP_MSUB, MD_OP_MSUBU};
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide on {hi,lo}.
module muldiv_step
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                      mode,
  input  logic [2*DATA_WIDTH-1:0]   partial,
  input  logic [DATA_WIDTH-1:0]     operand,
  output logic [2*DATA_WIDTH-1:0]   next_partial
);

  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;
  logic [DATA_WIDTH:0]   sum;
  logic [DATA_WIDTH:0]   rem_shift;
  logic [DATA_WIDTH:0]   diff;

  always_comb begin
    hi           = partial[2*DATA_WIDTH-1:DATA_WIDTH];
    lo           = partial[DATA_WIDTH-1:0];
    sum          = '0;
    rem_shift    = '0;
    diff         = '0;
    next_partial = partial;
    if (mode == STEP_MUL) begin
      // lo holds the unconsumed multiplier bits; the carry shifts into hi.
      sum          = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
      next_partial = {sum, lo[DATA_WIDTH-1:1]};
    end else begin
      rem_shift = {hi, lo[DATA_WIDTH-1]};
      diff      = rem_shift - {1'b0, operand};
      if (rem_shift >= {1'b0, operand}) begin
        next_partial = {diff[DATA_WIDTH-1:0], lo[DATA_WIDTH-2:0], 1'b1};
      end else begin
        next_partial = {rem_shift[DATA_WIDTH-1:0], lo[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide/MAC unit for the EX stage: FSM, iteration counter, sign fix-up and accumulate.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] operand1,
  input  logic [DATA_WIDTH-1:0] operand2,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic                  annul,
  output logic                  stall_request,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic [DATA_WIDTH-1:0] result_lo
);

  localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
  localparam int W2        = 2 * DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_ITER = CNT_WIDTH'(DATA_WIDTH - 1);

  md_state_e             state_q, state_d;
  md_op_e                op_q, op_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic                  sign1_q, sign1_d;
  logic                  sign2_q, sign2_d;
  logic                  div0_q, div0_d;
  logic [W2-1:0]         acc_q, acc_d;
  logic [W2-1:0]         part_q, part_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic [DATA_WIDTH-1:0] result_hi_q, result_hi_d;
  logic [DATA_WIDTH-1:0] result_lo_q, result_lo_d;

  md_op_e                op_in;
  logic                  wr_in;
  logic                  neg1_in, neg2_in, div0_in;
  logic [DATA_WIDTH-1:0] mag1_in, mag2_in;
  logic                  accept;
  logic                  step_mode;
  logic [W2-1:0]         step_next;
  logic [W2-1:0]         prod;
  logic [W2-1:0]         fix_res;
  logic [DATA_WIDTH-1:0] quo, rem;

  assign step_mode = is_div_op(op_q) ? STEP_DIV : STEP_MUL;

  muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .mode         (step_mode),
    .partial      (part_q),
    .operand      (opnd_q),
    .next_partial (step_next)
  );

  // Operand decode at accept: signed ops iterate on magnitudes.
  always_comb begin
    op_in   = md_op_e'(op);
    wr_in   = is_known_op(op_in);
    if (!wr_in) op_in = MD_OP_MULTU;
    neg1_in = is_signed_op(op_in) & operand1[DATA_WIDTH-1];
    neg2_in = is_signed_op(op_in) & operand2[DATA_WIDTH-1];
    mag1_in = neg1_in ? -operand1 : operand1;
    mag2_in = neg2_in ? -operand2 : operand2;
    div0_in = is_div_op(op_in) && (operand2 == '0);
  end

  // Sign correction and accumulate, consumed in FIX.
  always_comb begin
    prod    = (sign1_q ^ sign2_q) ? -part_q : part_q;
    quo     = part_q[DATA_WIDTH-1:0];
    rem     = part_q[W2-1:DATA_WIDTH];
    fix_res = prod;
    if (div0_q) begin
      fix_res = part_q;
    end else if (is_div_op(op_q)) begin
      fix_res = {(sign1_q ? -rem : rem), ((sign1_q ^ sign2_q) ? -quo : quo)};
    end else if (op_q == MD_OP_MADD || op_q == MD_OP_MADDU) begin
      fix_res = acc_q + prod;
    end else if (op_q == MD_OP_MSUB || op_q == MD_OP_MSUBU) begin
      fix_res = acc_q - prod;
    end
  end

  assign accept = start & ~annul & (state_q == MD_STATE_IDLE || state_q == MD_STATE_DONE);

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    wr_d        = wr_q;
    sign1_d     = sign1_q;
    sign2_d     = sign2_q;
    div0_d      = div0_q;
    acc_d       = acc_q;
    part_d      = part_q;
    opnd_d      = opnd_q;
    result_hi_d = result_hi_q;
    result_lo_d = result_lo_q;

    case (state_q)
      MD_STATE_RUN: begin
        if (annul) begin
          state_d = MD_STATE_IDLE;
        end else begin
          part_d = step_next;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ITER) state_d = MD_STATE_FIX;
        end
      end
      MD_STATE_FIX: begin
        if (annul) begin
          state_d = MD_STATE_IDLE;
        end else begin
          state_d = MD_STATE_DONE;
          if (wr_q) begin
            result_hi_d = fix_res[W2-1:DATA_WIDTH];
            result_lo_d = fix_res[DATA_WIDTH-1:0];
          end
        end
      end
      MD_STATE_DONE: state_d = MD_STATE_IDLE;
      default:       state_d = MD_STATE_IDLE;
    endcase

    if (accept) begin
      op_d    = op_in;
      wr_d    = wr_in;
      sign1_d = neg1_in;
      sign2_d = neg2_in;
      div0_d  = div0_in;
      acc_d   = {hi_in, lo_in};
      cnt_d   = '0;
      if (div0_in) begin
        // Divide by zero bypasses RUN; FIX passes this pattern straight through.
        part_d  = {operand1, {DATA_WIDTH{1'b1}}};
        opnd_d  = operand2;
        state_d = MD_STATE_FIX;
      end else if (is_div_op(op_in)) begin
        part_d  = {{DATA_WIDTH{1'b0}}, mag1_in};
        opnd_d  = mag2_in;
        state_d = MD_STATE_RUN;
      end else begin
        part_d  = {{DATA_WIDTH{1'b0}}, mag2_in};
        opnd_d  = mag1_in;
        state_d = MD_STATE_RUN;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= MD_STATE_IDLE;
      op_q        <= MD_OP_MULT;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      sign1_q     <= 1'b0;
      sign2_q     <= 1'b0;
      div0_q      <= 1'b0;
      acc_q       <= '0;
      part_q      <= '0;
      opnd_q      <= '0;
      result_hi_q <= '0;
      result_lo_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      sign1_q     <= sign1_d;
      sign2_q     <= sign2_d;
      div0_q      <= div0_d;
      acc_q       <= acc_d;
      part_q      <= part_d;
      opnd_q      <= opnd_d;
      result_hi_q <= result_hi_d;
      result_lo_q <= result_lo_d;
    end
  end

  assign stall_request = accept | (state_q == MD_STATE_RUN) | (state_q == MD_STATE_FIX);
  assign done          = (state_q == MD_STATE_DONE);
  assign result_hi     = result_hi_q;
  assign result_lo     = result_lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Bench for ex_muldiv: directed vector table, randomized ops against an arithmetic model, multi-cycle corner sequences.
module tb_ex_muldiv;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          annul = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  operand1 = '0;
  logic [W-1:0]  operand2 = '0;
  logic [W-1:0]  hi_in = '0;
  logic [W-1:0]  lo_in = '0;
  logic          stall_request;
  logic          done;
  logic [W-1:0]  result_hi;
  logic [W-1:0]  result_lo;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clock = ~clock;

  ex_muldiv #(.DATA_WIDTH(W)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .op            (op),
    .operand1      (operand1),
    .operand2      (operand2),
    .hi_in         (hi_in),
    .lo_in         (lo_in),
    .annul         (annul),
    .stall_request (stall_request),
    .done          (done),
    .result_hi     (result_hi),
    .result_lo     (result_lo)
  );

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic [31:0]  a;
    logic [31:0]  b;
    logic [31:0]  h;
    logic [31:0]  l;
    logic [63:0]  exp;
    int           lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end else begin
      $display("[TB] ok %s: %h", name, got);
    end
  endtask

  // Reference: HI/LO from plain 64-bit arithmetic on the architectural definitions.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] h,
                                            input logic [31:0] l);
    longint      sp, sq, sr;
    logic [63:0] up, acc;
    acc = {h, l};
    sp  = longint'($signed(a)) * longint'($signed(b));
    up  = {32'd0, a} * {32'd0, b};
    case (o)
      3'd0: return 64'(sp);
      3'd1: return up;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        sq = longint'($signed(a)) / longint'($signed(b));
        sr = longint'($signed(a)) % longint'($signed(b));
        return {sr[31:0], sq[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      3'd4: return acc + 64'(sp);
      3'd5: return acc + up;
      3'd6: return acc - 64'(sp);
      default: return acc - up;
    endcase
  endfunction

  task automatic issue(input string name, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] h, input logic [31:0] l,
                       input logic exp_stall);
    op = o; operand1 = a; operand2 = b; hi_in = h; lo_in = l; start = 1'b1;
    #1;
    chk({name, " accept stall"}, 64'(stall_request), 64'(exp_stall));
  endtask

  // Consumes the accepting edge, then counts cycles until done (exp_lat==0: expect none).
  task automatic wait_done(input string name, input int exp_lat, input int inject_at,
                           input int annul_at, output int lat);
    bit got;
    bit stall_ok;
    got = 1'b0;
    stall_ok = 1'b1;
    @(posedge clock);
    lat = 0;
    while (!got && lat < 80) begin
      @(negedge clock);
      lat++;
      start = 1'b0;
      annul = 1'b0;
      if (lat == inject_at) start = 1'b1;
      if (lat == annul_at) annul = 1'b1;
      #1;
      if (done) got = 1'b1;
      else if (exp_lat > 0 && !stall_request) stall_ok = 1'b0;
      if (annul_at > 0 && lat == annul_at + 1)
        chk({name, " idle after annul"}, 64'(stall_request), 64'd0);
    end
    if (exp_lat > 0) begin
      chk({name, " latency"}, got ? 64'(lat) : 64'd0, 64'(exp_lat));
      chk({name, " stall held"}, 64'(stall_ok), 64'd1);
      chk({name, " stall low in done"}, 64'(stall_request), 64'd0);
    end else begin
      chk({name, " no done"}, 64'(got), 64'd0);
    end
  endtask

  initial begin
    int          lat;
    int          cnt;
    logic [2:0]  ro;
    logic [31:0] ra, rb, rh, rl;
    int          rlat;

    vecs[0]  = '{"MULT -3x5",        3'd0, 32'hFFFF_FFFD, 32'd5,        32'd0, 32'd0,        64'hFFFF_FFFF_FFFF_FFF1, 34};
    vecs[1]  = '{"DIVU 100/7",       3'd3, 32'd100,       32'd7,        32'd0, 32'd0,        64'h0000_0002_0000_000E, 34};
    vecs[2]  = '{"DIV -7/2",         3'd2, 32'hFFFF_FFF9, 32'd2,        32'd0, 32'd0,        64'hFFFF_FFFF_FFFF_FFFD, 34};
    vecs[3]  = '{"DIV MIN/-1",       3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0,       64'h0000_0000_8000_0000, 34};
    vecs[4]  = '{"DIV 5/0",          3'd2, 32'd5,         32'd0,        32'd0, 32'd0,        64'h0000_0005_FFFF_FFFF, 2};
    vecs[5]  = '{"DIVU big/0",       3'd3, 32'hFFFF_FFFE, 32'd0,        32'd0, 32'd0,        64'hFFFF_FFFE_FFFF_FFFF, 2};
    vecs[6]  = '{"MADDU carry",      3'd5, 32'd2,         32'd1,        32'd0, 32'hFFFF_FFFF, 64'h0000_0001_0000_0001, 34};
    vecs[7]  = '{"MSUBU 0-1",        3'd7, 32'd1,         32'd1,        32'd0, 32'd0,        64'hFFFF_FFFF_FFFF_FFFF, 34};
    vecs[8]  = '{"MULTU max",        3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0,       64'hFFFF_FFFE_0000_0001, 34};
    vecs[9]  = '{"MADD 16+(-2x3)",   3'd4, 32'hFFFF_FFFE, 32'd3,        32'd0, 32'd16,       64'h0000_0000_0000_000A, 34};
    vecs[10] = '{"MSUB acc-(-1x-1)", 3'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd5, 32'd0,       64'h0000_0004_FFFF_FFFF, 34};
    vecs[11] = '{"DIV 7/-2",         3'd2, 32'd7,         32'hFFFF_FFFE, 32'd0, 32'd0,       64'h0000_0001_FFFF_FFFD, 34};

    repeat (3) @(negedge clock);
    #1;
    chk("reset results", {result_hi, result_lo}, 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset stall", 64'(stall_request), 64'd0);
    reset = 1'b1;
    @(negedge clock);

    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l, 1'b1);
      wait_done(vecs[i].name, vecs[i].lat, 0, 0, lat);
      chk({vecs[i].name, " result"}, {result_hi, result_lo}, vecs[i].exp);
      @(negedge clock);
      chk({vecs[i].name, " done pulse ends"}, 64'(done), 64'd0);
      chk({vecs[i].name, " result held"}, {result_hi, result_lo}, vecs[i].exp);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom();
      rb = $urandom();
      rh = $urandom();
      rl = $urandom();
      if ($urandom_range(0, 7) == 0) rb = 32'd0;
      if ($urandom_range(0, 9) == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 31);
      rlat = ((ro == 3'd2 || ro == 3'd3) && rb == 32'd0) ? 2 : 34;
      issue($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, rh, rl, 1'b1);
      wait_done($sformatf("rand%0d op%0d", i, ro), rlat, 0, 0, lat);
      chk($sformatf("rand%0d op%0d %h,%h acc %h%h", i, ro, ra, rb, rh, rl),
          {result_hi, result_lo}, ref_model(ro, ra, rb, rh, rl));
      @(negedge clock);
    end

    // Back-to-back: second request issued while the first one is in DONE.
    issue("b2b first", 3'd1, 32'd6, 32'd7, 32'd0, 32'd0, 1'b1);
    wait_done("b2b first", 34, 0, 0, lat);
    chk("b2b first result", {result_hi, result_lo}, 64'd42);
    issue("b2b second", 3'd0, 32'hFFFF_FFFD, 32'd5, 32'd0, 32'd0, 1'b1);
    wait_done("b2b second", 34, 0, 0, lat);
    chk("b2b second result", {result_hi, result_lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    @(negedge clock);

    // Stray start during RUN must be ignored.
    issue("start in RUN", 3'd3, 32'd1000, 32'd10, 32'd0, 32'd0, 1'b1);
    wait_done("start in RUN", 34, 5, 0, lat);
    chk("start in RUN result", {result_hi, result_lo}, 64'd100);
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      #1;
      if (done) cnt++;
    end
    chk("start in RUN extra done", 64'(cnt), 64'd0);

    // annul in RUN cycle 10.
    issue("annul RUN", 3'd0, 32'd3, 32'd3, 32'd0, 32'd0, 1'b1);
    wait_done("annul RUN", 0, 0, 10, lat);
    chk("annul RUN results unchanged", {result_hi, result_lo}, 64'd100);

    // annul together with start: no accept.
    @(negedge clock);
    annul = 1'b1;
    issue("annul+start", 3'd1, 32'd9, 32'd9, 32'd0, 32'd0, 1'b0);
    wait_done("annul+start", 0, 0, 0, lat);
    chk("annul+start stall", 64'(stall_request), 64'd0);
    chk("annul+start results unchanged", {result_hi, result_lo}, 64'd100);

    // Asynchronous reset in the middle of RUN.
    @(negedge clock);
    issue("reset mid-RUN", 3'd1, 32'd5, 32'd5, 32'd0, 32'd0, 1'b1);
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(negedge clock);
    reset = 1'b0;
    #1;
    chk("reset mid-RUN results", {result_hi, result_lo}, 64'd0);
    chk("reset mid-RUN done", 64'(done), 64'd0);
    chk("reset mid-RUN stall", 64'(stall_request), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    cnt = 0;
    repeat (40) begin
      @(negedge clock);
      #1;
      if (done) cnt++;
    end
    chk("reset mid-RUN no done", 64'(cnt), 64'd0);
    chk("reset mid-RUN results stay 0", {result_hi, result_lo}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
